// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: captures one EX/MEM access, runs req/gnt/rvalid on the data bus, stalls the pipeline.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic        i_memread,
    input  logic        i_memwrite,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic        o_stall,
    output logic [31:0] o_load_data,
    output logic        o_done,
    output logic        o_misaligned,
    output logic        o_bus_err,
    output logic        o_dmem_req,
    input  logic        i_dmem_gnt,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [3:0]  o_dmem_be,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [2:0]     funct3_q, funct3_d;
    logic           we_q, we_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    load_data_q, load_data_d;
    logic           bus_err_q, bus_err_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic           mis_q, mis_d;
`endif

    logic           start;
    logic           mis_in;
    logic           req;
    logic [3:0]     be_c;
    logic [31:0]    wdata_c;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    load_ext;

    assign start = i_valid & (i_memread | i_memwrite);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        mis_in = 1'b0;
        case (i_funct3[1:0])
            2'b00:   mis_in = 1'b0;
            2'b01:   mis_in = i_addr[0];
            default: mis_in = |i_addr[1:0];
        endcase
    end
`else
    assign mis_in = 1'b0;
`endif

    // Lane steering for the captured access; funct3[1:0] 00=B, 01=H, else W.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_q[1:0];
                wdata_c = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata_q[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wdata_q;
            end
        endcase
    end

    always_comb begin
        byte_sel = i_dmem_rdata[7:0];
        case (addr_q[1:0])
            2'b00: byte_sel = i_dmem_rdata[7:0];
            2'b01: byte_sel = i_dmem_rdata[15:8];
            2'b10: byte_sel = i_dmem_rdata[23:16];
            2'b11: byte_sel = i_dmem_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, byte_sel};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        bus_err_d   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d       = 1'b0;
`endif
        o_stall     = 1'b0;
        req         = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    o_stall     = 1'b1;
                    addr_d      = i_addr;
                    wdata_d     = i_wdata;
                    funct3_d    = i_funct3;
                    we_d        = i_memwrite;
                    cnt_d       = '0;
                    load_data_d = 32'h0;
                    if (mis_in) begin
                        state_d = DONE;
`ifdef LSU_MISALIGN_TRAP_EN
                        mis_d   = 1'b1;
`endif
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                o_stall = 1'b1;
                req     = 1'b1;
                if (i_dmem_gnt) begin
                    cnt_d   = '0;
                    state_d = we_q ? DONE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid) begin
                    load_data_d = load_ext;
                    state_d     = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Response never came: abandon and report on the DONE cycle.
                    bus_err_d   = 1'b1;
                    load_data_d = 32'h0;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            funct3_q    <= 3'b000;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            load_data_q <= 32'h0;
            bus_err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q       <= mis_d;
`endif
        end
    end

    // Bus fields are only driven during REQ so they read zero when no request is open.
    assign o_dmem_req   = req;
    assign o_dmem_we    = req & we_q;
    assign o_dmem_addr  = req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign o_dmem_be    = req ? be_c : 4'b0000;
    assign o_dmem_wdata = req ? wdata_c : 32'h0;
    assign o_done       = (state_q == DONE);
    assign o_load_data  = load_data_q;
    assign o_bus_err    = bus_err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign o_misaligned = mis_q;
`else
    assign o_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: inputs driven after the falling edge, outputs checked 1 ns later.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_valid, i_memread, i_memwrite;
    logic [31:0] i_addr, i_wdata;
    logic [2:0]  i_funct3;
    logic        o_stall, o_done, o_misaligned, o_bus_err;
    logic [31:0] o_load_data;
    logic        o_dmem_req, i_dmem_gnt, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;

    int tests = 0;
    int fails = 0;
    int gnt_count = 0;
    int base;
    int req_cycles;
    int waits;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT(255)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_memread    (i_memread),
        .i_memwrite   (i_memwrite),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_funct3     (i_funct3),
        .o_stall      (o_stall),
        .o_load_data  (o_load_data),
        .o_done       (o_done),
        .o_misaligned (o_misaligned),
        .o_bus_err    (o_bus_err),
        .o_dmem_req   (o_dmem_req),
        .i_dmem_gnt   (i_dmem_gnt),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_be    (o_dmem_be),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_rvalid(i_dmem_rvalid),
        .i_dmem_rdata (i_dmem_rdata)
    );

    always @(posedge clk) begin
        if (o_dmem_req && i_dmem_gnt) gnt_count <= gnt_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("[TB] check %s observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    initial begin
        i_reset = 1'b1; i_valid = 1'b0; i_memread = 1'b0; i_memwrite = 1'b0;
        i_addr = 32'h0; i_wdata = 32'h0; i_funct3 = 3'b000;
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", 32'(o_stall), 32'h0);
        chk("rst_done", 32'(o_done), 32'h0);
        chk("rst_mis", 32'(o_misaligned), 32'h0);
        chk("rst_buserr", 32'(o_bus_err), 32'h0);
        chk("rst_req", 32'(o_dmem_req), 32'h0);
        chk("rst_we", 32'(o_dmem_we), 32'h0);
        chk("rst_addr", o_dmem_addr, 32'h0);
        chk("rst_be", 32'(o_dmem_be), 32'h0);
        chk("rst_wdata", o_dmem_wdata, 32'h0);
        chk("rst_ldata", o_load_data, 32'h0);
        @(negedge clk); i_reset = 1'b0;

        // SB 0x1003, zero-wait grant
        @(negedge clk);
        i_valid = 1'b1; i_memwrite = 1'b1; i_addr = 32'h1003; i_wdata = 32'h000000A5;
        i_funct3 = 3'b000; i_dmem_gnt = 1'b1;
        #1;
        chk("sb_idle_stall", 32'(o_stall), 32'h1);
        chk("sb_idle_req", 32'(o_dmem_req), 32'h0);
        @(negedge clk); i_valid = 1'b0; i_memwrite = 1'b0; #1;
        chk("sb_req", 32'(o_dmem_req), 32'h1);
        chk("sb_we", 32'(o_dmem_we), 32'h1);
        chk("sb_addr", o_dmem_addr, 32'h00001000);
        chk("sb_be", 32'(o_dmem_be), 32'h8);
        chk("sb_wdata", o_dmem_wdata, 32'hA5A5A5A5);
        chk("sb_req_stall", 32'(o_stall), 32'h1);
        @(negedge clk); i_dmem_gnt = 1'b0; #1;
        chk("sb_done", 32'(o_done), 32'h1);
        chk("sb_done_stall", 32'(o_stall), 32'h0);
        chk("sb_done_req", 32'(o_dmem_req), 32'h0);
        @(negedge clk); #1;
        chk("sb_after_done", 32'(o_done), 32'h0);

        // LB 0x2001, grant delayed 3 cycles
        @(negedge clk);
        i_valid = 1'b1; i_memread = 1'b1; i_addr = 32'h2001; i_funct3 = 3'b000; i_dmem_gnt = 1'b0;
        #1;
        chk("lb_idle_stall", 32'(o_stall), 32'h1);
        @(negedge clk); i_valid = 1'b0; i_memread = 1'b0;
        req_cycles = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 3) i_dmem_gnt = 1'b1;
            #1;
            if (o_dmem_req) req_cycles++;
            if (k == 0) begin
                chk("lb_be", 32'(o_dmem_be), 32'h2);
                chk("lb_addr", o_dmem_addr, 32'h00002000);
            end
        end
        chk("lb_req_cycles", 32'(req_cycles), 32'd4);
        @(negedge clk); i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h00008000; #1;
        chk("lb_wait_req", 32'(o_dmem_req), 32'h0);
        chk("lb_wait_stall", 32'(o_stall), 32'h1);
        @(negedge clk); i_dmem_rvalid = 1'b0; #1;
        chk("lb_done", 32'(o_done), 32'h1);
        chk("lb_data", o_load_data, 32'hFFFFFF80);

        // LBU 0x2001
        @(negedge clk);
        i_valid = 1'b1; i_memread = 1'b1; i_addr = 32'h2001; i_funct3 = 3'b100; i_dmem_gnt = 1'b1;
        #1;
        @(negedge clk); i_valid = 1'b0; i_memread = 1'b0; #1;
        @(negedge clk); i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h00008000; #1;
        @(negedge clk); i_dmem_rvalid = 1'b0; #1;
        chk("lbu_done", 32'(o_done), 32'h1);
        chk("lbu_data", o_load_data, 32'h00000080);

        // LH 0x3003 (misaligned halfword)
        @(negedge clk);
        i_valid = 1'b1; i_memread = 1'b1; i_addr = 32'h3003; i_funct3 = 3'b001; i_dmem_gnt = 1'b1;
        #1;
`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge clk); i_valid = 1'b0; i_memread = 1'b0; #1;
        chk("lh_mis_done", 32'(o_done), 32'h1);
        chk("lh_mis_flag", 32'(o_misaligned), 32'h1);
        chk("lh_mis_noreq", 32'(o_dmem_req), 32'h0);
        chk("lh_mis_data", o_load_data, 32'h0);
        @(negedge clk); i_dmem_gnt = 1'b0; #1;
        chk("lh_mis_clear", 32'(o_misaligned), 32'h0);
`else
        @(negedge clk); i_valid = 1'b0; i_memread = 1'b0; #1;
        chk("lh_be", 32'(o_dmem_be), 32'hC);
        chk("lh_addr", o_dmem_addr, 32'h00003000);
        @(negedge clk); i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hBEEF1234; #1;
        @(negedge clk); i_dmem_rvalid = 1'b0; #1;
        chk("lh_done", 32'(o_done), 32'h1);
        chk("lh_mis_flag", 32'(o_misaligned), 32'h0);
        chk("lh_data", o_load_data, 32'hFFFFBEEF);
        @(negedge clk); #1;
`endif

        // SH 0x0002: upper-half lanes, replicated data
        @(negedge clk);
        i_valid = 1'b1; i_memwrite = 1'b1; i_addr = 32'h0000_0002; i_wdata = 32'h1234ABCD;
        i_funct3 = 3'b001; i_dmem_gnt = 1'b1;
        #1;
        @(negedge clk); i_valid = 1'b0; i_memwrite = 1'b0; #1;
        chk("sh_be", 32'(o_dmem_be), 32'hC);
        chk("sh_wdata", o_dmem_wdata, 32'hABCDABCD);
        @(negedge clk); i_dmem_gnt = 1'b0; #1;
        chk("sh_done", 32'(o_done), 32'h1);

        // LW 0x100 with no response: timeout
        @(negedge clk);
        i_valid = 1'b1; i_memread = 1'b1; i_addr = 32'h0000_0100; i_funct3 = 3'b010; i_dmem_gnt = 1'b1;
        #1;
        @(negedge clk); i_valid = 1'b0; i_memread = 1'b0; #1;
        chk("to_be", 32'(o_dmem_be), 32'hF);
        @(negedge clk); i_dmem_gnt = 1'b0; #1;
        waits = 0;
        while (!o_done && waits < 400) begin
            waits++;
            @(negedge clk); #1;
        end
        chk("to_wait_cycles", 32'(waits), 32'd255);
        chk("to_buserr", 32'(o_bus_err), 32'h1);
        chk("to_data", o_load_data, 32'h0);
        @(negedge clk); #1;
        chk("to_buserr_pulse", 32'(o_bus_err), 32'h0);
        chk("to_idle_stall", 32'(o_stall), 32'h0);

        // Back-to-back SW then LW, zero-wait bus, rvalid held high
        base = gnt_count;
        i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'hCAFEBABE;
        @(negedge clk);
        i_valid = 1'b1; i_memwrite = 1'b1; i_addr = 32'h0000_0040; i_wdata = 32'h12345678; i_funct3 = 3'b010;
        #1;
        chk("b2b_sw_stall", 32'(o_stall), 32'h1);
        @(negedge clk); i_valid = 1'b0; i_memwrite = 1'b0; #1;
        chk("b2b_sw_we", 32'(o_dmem_we), 32'h1);
        chk("b2b_sw_wdata", o_dmem_wdata, 32'h12345678);
        chk("b2b_sw_addr", o_dmem_addr, 32'h00000040);
        @(negedge clk); #1;
        chk("b2b_sw_done", 32'(o_done), 32'h1);
        @(negedge clk);
        i_valid = 1'b1; i_memread = 1'b1; i_addr = 32'h0000_0044; i_funct3 = 3'b010;
        #1;
        chk("b2b_lw_stall", 32'(o_stall), 32'h1);
        @(negedge clk); i_valid = 1'b0; i_memread = 1'b0; #1;
        chk("b2b_lw_req", 32'(o_dmem_req), 32'h1);
        chk("b2b_lw_we", 32'(o_dmem_we), 32'h0);
        chk("b2b_lw_addr", o_dmem_addr, 32'h00000044);
        @(negedge clk); #1;
        chk("b2b_lw_wait", 32'(o_done), 32'h0);
        @(negedge clk); #1;
        chk("b2b_lw_done", 32'(o_done), 32'h1);
        chk("b2b_lw_data", o_load_data, 32'hCAFEBABE);
        @(negedge clk); i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; #1;
        chk("b2b_grants", 32'(gnt_count - base), 32'd2);
        chk("b2b_idle_done", 32'(o_done), 32'h0);

        // Reset during WAIT_RSP, then a late rvalid
        @(negedge clk);
        i_valid = 1'b1; i_memread = 1'b1; i_addr = 32'h0000_0080; i_funct3 = 3'b010; i_dmem_gnt = 1'b1;
        #1;
        @(negedge clk); i_valid = 1'b0; i_memread = 1'b0; #1;
        @(negedge clk); i_dmem_gnt = 1'b0; i_reset = 1'b1; #1;
        chk("rma_wait_stall", 32'(o_stall), 32'h1);
        @(negedge clk); i_reset = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h00000055; #1;
        chk("rma_stall", 32'(o_stall), 32'h0);
        chk("rma_done", 32'(o_done), 32'h0);
        chk("rma_req", 32'(o_dmem_req), 32'h0);
        chk("rma_addr", o_dmem_addr, 32'h0);
        chk("rma_buserr", 32'(o_bus_err), 32'h0);
        chk("rma_ldata", o_load_data, 32'h0);
        @(negedge clk); i_dmem_rvalid = 1'b0; #1;
        chk("rma_late_done", 32'(o_done), 32'h0);
        chk("rma_late_ldata", o_load_data, 32'h0);
        chk("rma_late_stall", 32'(o_stall), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
